// File: rtl/wb_axis_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_axis_bridge_if
//
// Bundles the Wishbone slave port and both AXI-Stream ports of the
// Wishbone <-> AXI-Stream bridge.
//
// Handshake semantics:
//   Wishbone : a request is cyc & stb on a decoded address; the bridge
//              answers with a single-cycle wbs_ack_o, and wbs_dat_o is only
//              meaningful (non-zero) in that ack cycle.
//   AXI-S    : a beat transfers on the rising edge where tvalid & tready
//              are both high; the source holds tdata/tlast stable while
//              tvalid is high and tready is low.
//
// Modports:
//   slave  - the bridge side (Wishbone slave, TX stream master,
//            RX stream slave).
//   master - the environment side (Wishbone master, TX stream sink,
//            RX stream source).
// ---------------------------------------------------------------------------
interface wb_axis_bridge_if;
    // Wishbone
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    // TX stream (bridge -> FIR ss_*)
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    // RX stream (FIR sm_* -> bridge)
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output m_tvalid, m_tdata, m_tlast,
        input  m_tready,
        input  s_tvalid, s_tdata, s_tlast,
        output s_tready
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  m_tvalid, m_tdata, m_tlast,
        output m_tready,
        output s_tvalid, s_tdata, s_tlast,
        input  s_tready
    );
endinterface

// File: rtl/wb_axis_bridge.sv
// ---------------------------------------------------------------------------
// wb_axis_bridge
//
// Wishbone slave to AXI-Stream bridge in front of the FIR engine.
//   * Writes to ADDR_X / ADDR_XL push {tlast, data} into a TX FIFO that is
//     streamed out on the m_* AXI-Stream master.
//   * Beats arriving on the s_* AXI-Stream slave are buffered in an RX FIFO
//     and returned by reads of ADDR_Y.
//   * ADDR_STAT reads FIFO levels / flags / sticky timeout error; writing it
//     with bit 5 set clears the error.
//
// Ports:
//   wb_clk_i     - single clock
//   wb_rst_i     - synchronous active-high reset
//   bus          - wb_axis_bridge_if.slave (Wishbone + both streams)
//   dbg_state_o  - current access FSM state (0 IDLE, 1 WAIT, 2 RESP)
// ---------------------------------------------------------------------------
module wb_axis_bridge #(
    parameter logic [31:0] ADDR_X    = 32'h3000_0080,
    parameter logic [31:0] ADDR_XL   = 32'h3000_008C,
    parameter logic [31:0] ADDR_Y    = 32'h3000_0084,
    parameter logic [31:0] ADDR_STAT = 32'h3000_0088,
    parameter int          DEPTH     = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_axis_bridge_if.slave        bus,
    output logic [1:0]             dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic [31:0]     dat_q,   dat_d;
    logic            err_q;

    logic [32:0]     tx_mem [DEPTH];
    logic [AW-1:0]   tx_wr_q, tx_rd_q;
    logic [CW-1:0]   tx_count_q;

    logic [32:0]     rx_mem [DEPTH];
    logic [AW-1:0]   rx_wr_q, rx_rd_q;
    logic [CW-1:0]   rx_count_q;

    // Byte selects are ignored: every access is a full word.
    logic unused_sel;
    assign unused_sel = ^bus.wbs_sel_i;

    // ------------------------------------------------------------------
    // FIFO flags
    // ------------------------------------------------------------------
    logic tx_full, tx_empty, rx_full, rx_empty;
    assign tx_full  = (tx_count_q == CW'(DEPTH));
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == CW'(DEPTH));
    assign rx_empty = (rx_count_q == '0);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic hit_x, hit_xl, hit_y, hit_stat, req;
    assign hit_x    = (bus.wbs_adr_i == ADDR_X);
    assign hit_xl   = (bus.wbs_adr_i == ADDR_XL);
    assign hit_y    = (bus.wbs_adr_i == ADDR_Y);
    assign hit_stat = (bus.wbs_adr_i == ADDR_STAT);
    assign req      = bus.wbs_cyc_i & bus.wbs_stb_i &
                      (hit_x | hit_xl | hit_y | hit_stat);

    // ------------------------------------------------------------------
    // Status word
    // ------------------------------------------------------------------
    logic [31:0] stat_word;
    logic        rx_head_last;
    assign rx_head_last = ~rx_empty & rx_mem[rx_rd_q][32];

    always_comb begin
        stat_word        = '0;
        stat_word[0]     = tx_full;
        stat_word[1]     = tx_empty;
        stat_word[2]     = rx_full;
        stat_word[3]     = rx_empty;
        stat_word[4]     = rx_head_last;
        stat_word[5]     = err_q;
        stat_word[11:8]  = 4'(tx_count_q);
        stat_word[15:12] = 4'(rx_count_q);
    end

    // ------------------------------------------------------------------
    // Serviceability of the presented access, judged on registered counts
    // so a full TX FIFO never accepts a push in the cycle it is popped.
    // ------------------------------------------------------------------
    logic        svc_ok;
    logic [31:0] rd_val;

    always_comb begin
        svc_ok = 1'b1;
        rd_val = '0;
        if (bus.wbs_we_i) begin
            if (hit_x | hit_xl) begin
                svc_ok = ~tx_full;
            end
        end else begin
            if (hit_y) begin
                svc_ok = ~rx_empty;
                rd_val = rx_mem[rx_rd_q][31:0];
            end else if (hit_stat) begin
                rd_val = stat_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    logic do_acc;
    logic timeout_hit;

    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        do_acc      = 1'b0;
        timeout_hit = 1'b0;
        dat_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (svc_ok) begin
                        do_acc  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        stall_d = '0;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (svc_ok) begin
                    do_acc  = 1'b1;
                    state_d = S_RESP;
                end else if (!bus.wbs_we_i && hit_y &&
                             stall_q == SW'(TIMEOUT - 1)) begin
                    // The counter would reach TIMEOUT this cycle: give up,
                    // so the ack lands TIMEOUT+1 cycles after the request.
                    timeout_hit = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_acc && !bus.wbs_we_i) begin
            dat_d = rd_val;
        end
        if (timeout_hit) begin
            dat_d = TIMEOUT_DATA;
        end
    end

    // Side effects of a serviced access
    logic tx_push, rx_pop_wb, err_set, err_clr;
    assign tx_push   = do_acc & bus.wbs_we_i & (hit_x | hit_xl);
    assign rx_pop_wb = do_acc & ~bus.wbs_we_i & hit_y;
    assign err_set   = timeout_hit;
    assign err_clr   = do_acc & bus.wbs_we_i & hit_stat & bus.wbs_dat_i[5];

    // Stream handshakes
    logic tx_pop, rx_push;
    assign tx_pop  = ~tx_empty & bus.m_tready;
    assign rx_push = bus.s_tvalid & bus.s_tready;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            stall_q <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            dat_q   <= dat_d;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem[i] <= '0;
            end
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr_q] <= {hit_xl, bus.wbs_dat_i};
                tx_wr_q         <= tx_wr_q + AW'(1);
            end
            if (tx_pop) begin
                tx_rd_q <= tx_rd_q + AW'(1);
            end
            tx_count_q <= tx_count_q + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem[i] <= '0;
            end
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr_q] <= {bus.s_tlast, bus.s_tdata};
                rx_wr_q         <= rx_wr_q + AW'(1);
            end
            if (rx_pop_wb) begin
                rx_rd_q <= rx_rd_q + AW'(1);
            end
            rx_count_q <= rx_count_q + CW'(rx_push) - CW'(rx_pop_wb);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wbs_ack_o = (state_q == S_RESP);
    assign bus.wbs_dat_o = dat_q;

    assign bus.m_tvalid  = ~tx_empty;
    assign bus.m_tdata   = tx_mem[tx_rd_q][31:0];
    assign bus.m_tlast   = tx_mem[tx_rd_q][32];

    // Held low through reset; otherwise ready whenever the RX FIFO has room.
    assign bus.s_tready  = ~wb_rst_i & ~rx_full;

    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_wb_axis_bridge.sv
module tb_wb_axis_bridge;

    localparam int          DEPTH     = 4;
    localparam int          TIMEOUT   = 255;
    localparam logic [31:0] ADDR_X    = 32'h3000_0080;
    localparam logic [31:0] ADDR_XL   = 32'h3000_008C;
    localparam logic [31:0] ADDR_Y    = 32'h3000_0084;
    localparam logic [31:0] ADDR_STAT = 32'h3000_0088;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_axis_bridge_if bus();
    logic [1:0] dbg_state;

    wb_axis_bridge #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    logic [32:0] exp_q[$];   // TX words accepted by Wishbone, in order
    logic [32:0] obs_q[$];   // TX beats seen on the stream
    logic [32:0] rx_q[$];    // RX FIFO model contents
    int          tx_level;   // words held in the TX FIFO
    logic        err_m;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          tready_mode = 0;   // 0: low, 1: high, 2: random
    int          tv_cycles   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_stat();
        logic [31:0] s;
        s        = '0;
        s[0]     = (tx_level == DEPTH);
        s[1]     = (tx_level == 0);
        s[2]     = (rx_q.size() == DEPTH);
        s[3]     = (rx_q.size() == 0);
        s[4]     = (rx_q.size() != 0) ? rx_q[0][32] : 1'b0;
        s[5]     = err_m;
        s[11:8]  = 4'(tx_level);
        s[15:12] = 4'(rx_q.size());
        return s;
    endfunction

    // TX sink: drives m_tready per mode, then records beats that will
    // transfer on the next rising edge.
    always @(negedge clk) begin
        #2;
        case (tready_mode)
            0:       bus.m_tready = 1'b0;
            1:       bus.m_tready = 1'b1;
            default: bus.m_tready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (!rst && bus.m_tvalid) tv_cycles++;
        if (!rst && bus.m_tvalid && bus.m_tready) begin
            obs_q.push_back({bus.m_tlast, bus.m_tdata});
            tx_level--;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_access(input logic we, input logic [31:0] adr,
                             input logic [31:0] wdat, input int budget,
                             output logic acked, output logic [31:0] rdat,
                             output int lat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        bus.wbs_sel_i = 4'hF;
        lat = 0; acked = 1'b0; rdat = '0;
        while (!acked && lat < budget) begin
            @(negedge clk);
            lat++;
            if (bus.wbs_ack_o) begin
                acked = 1'b1;
                rdat  = bus.wbs_dat_o;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] d,
                            input string tag, output int lat);
        logic        acked;
        logic [31:0] r;
        wb_access(1'b1, adr, d, 2000, acked, r, lat);
        check_eq({tag, "_ack"}, 32'(acked), 32'd1);
        if (acked && (adr == ADDR_X || adr == ADDR_XL)) begin
            exp_q.push_back({adr == ADDR_XL, d});
            tx_level++;
        end
        if (acked && adr == ADDR_STAT && d[5]) err_m = 1'b0;
    endtask

    task automatic y_read_check(input string tag, output int lat);
        logic        acked;
        logic [31:0] r, e;
        logic [32:0] head;
        wb_access(1'b0, ADDR_Y, '0, 2000, acked, r, lat);
        check_eq({tag, "_ack"}, 32'(acked), 32'd1);
        if (rx_q.size() != 0) begin
            head = rx_q.pop_front();
            e    = head[31:0];
        end else begin
            e     = 32'hDEAD_BEEF;
            err_m = 1'b1;
        end
        check_eq(tag, r, e);
    endtask

    task automatic stat_check(input string tag);
        logic        acked;
        logic [31:0] r;
        int          lat, saved;
        saved = tready_mode;
        tready_mode = 0;
        repeat (2) @(negedge clk);
        wb_access(1'b0, ADDR_STAT, '0, 50, acked, r, lat);
        check_eq({tag, "_ack"}, 32'(acked), 32'd1);
        check_eq(tag, r, model_stat());
        tready_mode = saved;
    endtask

    task automatic rx_send(input logic [31:0] d, input logic last,
                           input int budget, output int lat);
        logic done;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        bus.s_tlast  = last;
        lat = 0; done = 1'b0;
        while (!done && lat < budget) begin
            if (bus.s_tready) begin
                @(negedge clk);
                done = 1'b1;
                rx_q.push_back({last, d});
            end else begin
                @(negedge clk);
            end
            lat++;
        end
        bus.s_tvalid = 1'b0;
        check_eq("rx_send_done", 32'(done), 32'd1);
    endtask

    task automatic tx_drain(input string tag);
        int n;
        logic [32:0] o, e;
        tready_mode = 1;
        n = 0;
        while (tx_level > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_eq({tag, "_level"}, 32'(tx_level), 32'd0);
        check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check_eq({tag, "_data"}, o[31:0], e[31:0]);
            check_eq({tag, "_last"}, 32'(o[32]), 32'(e[32]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int          lat, lat2, op, acks;
        logic        acked;
        logic [31:0] r, d;

        rst = 1'b1;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        bus.s_tvalid = 0; bus.s_tdata = 0; bus.s_tlast = 0;
        bus.m_tready = 0;
        tx_level = 0; err_m = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ack",      32'(bus.wbs_ack_o), 32'd0);
        check_eq("rst_dat",      bus.wbs_dat_o,      32'd0);
        check_eq("rst_m_tvalid", 32'(bus.m_tvalid),  32'd0);
        check_eq("rst_m_tdata",  bus.m_tdata,        32'd0);
        check_eq("rst_m_tlast",  32'(bus.m_tlast),   32'd0);
        check_eq("rst_s_tready", 32'(bus.s_tready),  32'd0);
        check_eq("rst_state",    32'(dbg_state),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_s_tready", 32'(bus.s_tready), 32'd1);
        stat_check("stat_after_reset");

        // Single TX word
        tready_mode = 1;
        repeat (2) @(negedge clk);
        tv_cycles = 0;
        do_write(ADDR_X, 32'h0000_0005, "single_tx", lat);
        check_eq("single_tx_lat", 32'(lat), 32'd1);
        repeat (5) @(negedge clk);
        check_eq("single_tx_valid_cycles", 32'(tv_cycles), 32'd1);
        tx_drain("single_tx_stream");

        // TX full stall
        tready_mode = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            do_write(ADDR_X, $urandom, "fill_tx", lat);
            check_eq("fill_tx_lat", 32'(lat), 32'd1);
        end
        stat_check("stat_tx_full");
        fork
            do_write(ADDR_XL, 32'hCAFE_0005, "stall_tx", lat);
            begin
                repeat (10) @(negedge clk);
                tready_mode = 1;
                @(negedge clk);
                tready_mode = 0;
            end
        join
        check_eq("stall_tx_lat", 32'(lat), 32'd12);
        tx_drain("stall_tx_stream");

        // RX path
        tready_mode = 0;
        rx_send(32'h11, 1'b0, 20, lat);
        rx_send(32'h22, 1'b1, 20, lat);
        stat_check("stat_rx_two");
        y_read_check("rx_y_first", lat);
        stat_check("stat_rx_head_last");
        y_read_check("rx_y_second", lat);

        // RX backpressure
        for (int i = 0; i < DEPTH; i++) begin
            rx_send($urandom, 1'($urandom_range(0, 1)), 20, lat);
            check_eq("rx_fill_lat", 32'(lat), 32'd1);
        end
        check_eq("rx_full_tready", 32'(bus.s_tready), 32'd0);
        stat_check("stat_rx_full");
        fork
            rx_send(32'h5555_AAAA, 1'b1, 20, lat2);
            y_read_check("rx_bp_read", lat);
        join
        check_eq("rx_bp_read_lat", 32'(lat), 32'd1);
        check_eq("rx_bp_beat_lat", 32'(lat2), 32'd2);
        while (rx_q.size() != 0) y_read_check("rx_bp_drain", lat);

        // Timeout on empty RX
        y_read_check("timeout_data", lat);
        check_eq("timeout_lat", 32'(lat), 32'(TIMEOUT + 1));
        stat_check("stat_err_set");
        do_write(ADDR_STAT, 32'h0000_0000, "stat_noclr", lat);
        stat_check("stat_err_kept");
        do_write(ADDR_STAT, 32'h0000_0020, "stat_clr", lat);
        stat_check("stat_err_cleared");

        // Side accesses: X read returns 0, Y write ignored, unmapped silent
        wb_access(1'b0, ADDR_X, '0, 20, acked, r, lat);
        check_eq("x_read_ack", 32'(acked), 32'd1);
        check_eq("x_read_data", r, 32'd0);
        do_write(ADDR_Y, 32'h1234_5678, "y_write", lat);
        stat_check("stat_after_side");
        wb_access(1'b0, 32'h3000_0090, '0, 8, acked, r, lat);
        check_eq("unmapped_ack", 32'(acked), 32'd0);

        // Randomized mix against the model
        tready_mode = 2;
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 5);
            d  = $urandom;
            case (op)
                0: do_write(ADDR_X,  d, "rnd_x",  lat);
                1: do_write(ADDR_XL, d, "rnd_xl", lat);
                2: if (rx_q.size() != 0) y_read_check("rnd_y", lat);
                   else rx_send(d, 1'($urandom_range(0, 1)), 20, lat);
                3: if (rx_q.size() < DEPTH) rx_send(d, 1'($urandom_range(0, 1)), 20, lat);
                   else y_read_check("rnd_y", lat);
                4: stat_check("rnd_stat");
                default: begin
                    wb_access(1'b0, ADDR_XL, '0, 20, acked, r, lat);
                    check_eq("rnd_xl_read", r, 32'd0);
                end
            endcase
        end
        tx_drain("rnd_stream");
        while (rx_q.size() != 0) y_read_check("rnd_rx_drain", lat);

        // Reset in the middle of a stalled TX write, with err set
        y_read_check("pre_rst_timeout", lat);
        tready_mode = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) do_write(ADDR_X, $urandom, "rst_fill", lat);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = ADDR_X; bus.wbs_dat_i = 32'hBAD0_0001;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
        end
        rst = 1'b1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.wbs_ack_o) acks++;
        end
        check_eq("rst_stall_acks",     32'(acks),           32'd0);
        check_eq("rst_stall_m_tvalid", 32'(bus.m_tvalid),   32'd0);
        check_eq("rst_stall_s_tready", 32'(bus.s_tready),   32'd0);
        check_eq("rst_stall_dat",      bus.wbs_dat_o,       32'd0);
        rst = 1'b0;
        exp_q.delete(); obs_q.delete(); rx_q.delete();
        tx_level = 0; err_m = 1'b0;
        @(negedge clk);
        check_eq("rst_release_s_tready", 32'(bus.s_tready), 32'd1);
        wb_access(1'b0, ADDR_STAT, '0, 20, acked, r, lat);
        check_eq("rst_release_stat_lit", r, 32'h0000_000A);
        stat_check("rst_release_stat");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_axis_bridge.md
Name: wb_axis_bridge

Overview:
- Wishbone-slave to AXI-Stream bridge that sits directly downstream of the user-project Wishbone port and feeds the FIR engine's stream interfaces.
- Firmware writes samples to a TX data register. They are buffered in a TX FIFO and driven out as an AXI-Stream master (FIR ss_* side).
- FIR results arrive on an AXI-Stream slave (FIR sm_* side). They are buffered in an RX FIFO and returned on Wishbone reads of an RX data register.
- A status register exposes FIFO levels, the tlast flag and a sticky timeout error.

Parameters:
- ADDR_X, 32'h3000_0080: push TX word with tlast=0.
- ADDR_XL, 32'h3000_008C: push TX word with tlast=1.
- ADDR_Y, 32'h3000_0084: pop RX word.
- ADDR_STAT, 32'h3000_0088: status register (read) / error clear (write).
- DEPTH, 4: entries per FIFO. Must be a power of 2, range 2..8.
- TIMEOUT, 255: maximum cycles a Y read may stall before an error response.

Ports:
- wb_clk_i, in, 1: single clock for the whole block.
- wb_rst_i, in, 1: reset.
- wbs_cyc_i, in, 1: Wishbone cycle.
- wbs_stb_i, in, 1: Wishbone strobe.
- wbs_we_i, in, 1: write enable.
- wbs_sel_i, in, 4: byte selects. Ignored; every access is a full 32-bit word.
- wbs_adr_i, in, 32: byte address.
- wbs_dat_i, in, 32: write data.
- wbs_ack_o, out, 1: one-cycle acknowledge.
- wbs_dat_o, out, 32: read data. Valid only in the ack cycle; 0 otherwise.
- m_tvalid, out, 1: TX stream valid.
- m_tdata, out, 32: TX stream data.
- m_tlast, out, 1: TX stream last.
- m_tready, in, 1: TX stream ready (FIR ss_tready).
- s_tvalid, in, 1: RX stream valid (FIR sm_tvalid).
- s_tdata, in, 32: RX stream data.
- s_tlast, in, 1: RX stream last.
- s_tready, out, 1: RX stream ready.

Behaviour:
- Clock and reset (already decided): one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset clears both FIFOs (pointers, counts, storage), the error flag and the FSM (to IDLE). Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - m_tvalid=0, m_tdata=0, m_tlast=0.
  - s_tready=0 while reset is held; 1 in the first cycle after release (RX FIFO empty).
- Reset mid-transaction abandons the access with no ack. The master must restart it.
- Request: req = cyc & stb & (adr equals one of the four addresses). Other addresses produce no response; they are left to the upstream decoder.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with req: if the access is serviceable this cycle, perform it and go to RESP. Otherwise go to WAIT with stall counter = 0.
  - WAIT: re-evaluate every cycle. If serviceable, perform the access and go to RESP. If the request drops (cyc or stb low), go to IDLE with no side effect.
  - RESP: wbs_ack_o=1 for exactly this cycle, wbs_dat_o as specified below. Then go to IDLE. Requests are not sampled in RESP.
  - Latency: ack 1 cycle after req when serviceable immediately. Back-to-back accesses are 2 cycles apart minimum.
- Serviceability and effect per access:
  - Write ADDR_X / ADDR_XL: serviceable when tx_count < DEPTH, using the registered count at the start of the cycle. Pushes {last, wbs_dat_i}.
  - Read ADDR_Y: serviceable when rx_count > 0. Pops the head; wbs_dat_o = head data.
  - Read ADDR_Y timeout: if the counter reaches TIMEOUT in WAIT, ack with wbs_dat_o=32'hDEAD_BEEF, set err, pop nothing.
  - Write ADDR_X/ADDR_XL have no timeout; they stall until space is available.
  - Read ADDR_STAT: always serviceable. Returns:
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
    - [4] tlast of the RX head entry (0 if empty).
    - [5] err.
    - [11:8] tx_count, [15:12] rx_count.
    - All other bits 0.
  - Write ADDR_STAT: if wbs_dat_i[5]=1, clear err. Always serviceable.
  - Reads of ADDR_X/ADDR_XL return 0 with no push. Writes to ADDR_Y are acked and ignored.
- TX stream:
  - m_tvalid = tx not empty; m_tdata and m_tlast = head entry.
  - Pop on m_tvalid & m_tready.
  - Head is stable while m_tvalid=1 and m_tready=0.
- RX stream:
  - s_tready = rx not full, from the registered count.
  - Push {s_tlast, s_tdata} on s_tvalid & s_tready.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle: count unchanged, both take effect.
  - A full FIFO cannot accept a push in the same cycle it is popped; the push is accepted no earlier than the next cycle.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits.

Test Plan:
- Single TX: write 0x0000_0005 to ADDR_X with m_tready=1 -> ack 1 cycle later; m_tvalid=1 with m_tdata=5, m_tlast=0 for exactly one cycle.
- TX full stall: m_tready=0, write 5 words -> 4 acked. The 5th stalls until m_tready pulses once, then acks within 2 cycles; stream order is preserved.
- RX path: drive s_tdata 0x11, 0x22 (tlast=1 on 0x22) -> STAT[15:12]=2. Y reads return 0x11 then 0x22; STAT[4]=1 before the second read.
- RX backpressure: send 5 beats with no reads -> s_tready=0 after the 4th; the 5th beat is held until a Y read completes.
- Timeout: Y read with the RX FIFO empty -> ack exactly TIMEOUT+1 cycles after req with 0xDEAD_BEEF; STAT[5]=1. Writing 0x20 to ADDR_STAT clears it.
- Reset mid-stall: assert wb_rst_i during a stalled X write -> no ack; m_tvalid=0; STAT reads 0x0000_000A after release.
